// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Round-robin arbiter feeding a single UART transmitter, with
//            burst locking and a completion timeout.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int TIMEOUT_WIDTH = 16
) (
    input  logic                          axi_clk_i,
    input  logic                          axi_a_rst_n_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]            req_last_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic [NUM_REQ-1:0]            grant_o,
    output logic                          tx_enable_o,
    output logic [DATA_WIDTH-1:0]         tx_data_o,
    input  logic                          tx_complete_i,
    input  logic [TIMEOUT_WIDTH-1:0]      timeout_val_i,
    output logic                          busy_o,
    output logic                          timeout_err_o
);

    localparam int c_PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [c_PTR_W-1:0]       r_ptr;
    logic [c_PTR_W-1:0]       r_grant_idx;
    logic                     r_last;
    logic [TIMEOUT_WIDTH-1:0] r_cnt;

    logic [c_PTR_W-1:0]       w_win_idx;
    logic                     w_win_found;
    int                       w_cand;
    logic [c_PTR_W-1:0]       w_acc_idx;
    logic [NUM_REQ-1:0]       w_acc_oh;
    logic                     w_accept;
    logic                     w_cnt_hit;
    logic                     w_timeout;
    logic                     w_release;

    // Round-robin search starting just above the last burst owner.
    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = '0;
        w_cand      = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_cand = (int'(r_ptr) + i) % NUM_REQ;
            if (!w_win_found && req_valid_i[w_cand]) begin
                w_win_found = 1'b1;
                w_win_idx   = c_PTR_W'(w_cand);
            end
        end
    end

    assign w_cnt_hit = (timeout_val_i != '0) && (r_cnt == timeout_val_i);

    always_ff @(posedge axi_clk_i or negedge axi_a_rst_n_i) begin
        if (!axi_a_rst_n_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Completion beats timeout in WAIT; a handshake beats timeout in HOLD.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_acc_idx    = r_grant_idx;
        w_timeout    = 1'b0;
        w_release    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_win_found) begin
                    w_accept     = 1'b1;
                    w_acc_idx    = w_win_idx;
                    w_state_next = SEND;
                end
            end
            SEND: w_state_next = WAIT;
            WAIT: begin
                if (tx_complete_i) begin
                    w_state_next = r_last ? IDLE : HOLD;
                    w_release    = r_last;
                end else if (w_cnt_hit) begin
                    w_timeout    = 1'b1;
                    w_release    = 1'b1;
                    w_state_next = IDLE;
                end
            end
            HOLD: begin
                if (req_valid_i[r_grant_idx]) begin
                    w_accept     = 1'b1;
                    w_state_next = SEND;
                end else if (w_cnt_hit) begin
                    w_timeout    = 1'b1;
                    w_release    = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase

        w_acc_oh            = '0;
        w_acc_oh[w_acc_idx] = 1'b1;
        // Ready is forced low while reset is held, even with valid requests.
        req_ready_o = (w_accept && axi_a_rst_n_i) ? w_acc_oh : '0;
    end

    assign tx_enable_o   = (r_state == SEND);
    assign busy_o        = (r_state != IDLE);
    assign timeout_err_o = w_timeout;

    always_ff @(posedge axi_clk_i or negedge axi_a_rst_n_i) begin
        if (!axi_a_rst_n_i) begin
            r_ptr       <= c_PTR_W'(NUM_REQ - 1);
            r_grant_idx <= '0;
            r_last      <= 1'b0;
            r_cnt       <= '0;
            grant_o     <= '0;
            tx_data_o   <= '0;
        end else begin
            if (w_accept) begin
                tx_data_o   <= req_data_i[int'(w_acc_idx)*DATA_WIDTH +: DATA_WIDTH];
                r_last      <= req_last_i[w_acc_idx];
                r_grant_idx <= w_acc_idx;
                grant_o     <= w_acc_oh;
            end
            if (w_release) begin
                r_ptr   <= r_grant_idx;
                grant_o <= '0;
            end

            case (r_state)
                WAIT: begin
                    if (tx_complete_i) begin
                        r_cnt <= '0;
                    end else if (r_cnt != '1) begin
                        r_cnt <= r_cnt + TIMEOUT_WIDTH'(1);
                    end
                end
                HOLD: begin
                    if (r_cnt != '1) begin
                        r_cnt <= r_cnt + TIMEOUT_WIDTH'(1);
                    end
                end
                default: r_cnt <= '0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- NUM_REQ, 4, number of requesters.
- DATA_WIDTH, 8, byte width.
- TIMEOUT_WIDTH, 16, width of the completion-timeout counter.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- axi_clk_i, in, 1, sole clock; all logic on the rising edge.
- axi_a_rst_n_i, in, 1, reset, asynchronous, active-low.
- req_valid_i, in, NUM_REQ, per-requester byte valid.
- req_data_i, in, NUM_REQ*DATA_WIDTH, per-requester byte; requester k uses slice [k*DATA_WIDTH +: DATA_WIDTH].
- req_last_i, in, NUM_REQ, byte ends the requester's burst.
- req_ready_o, out, NUM_REQ, byte accepted when valid && ready.
- grant_o, out, NUM_REQ, one-hot owner of the transmitter; 0 when idle.
- tx_enable_o, out, 1, one-cycle start pulse to the UART transmitter.
- tx_data_o, out, DATA_WIDTH, byte to transmit.
- tx_complete_i, in, 1, transmitter finished the frame (pulse).
- timeout_val_i, in, TIMEOUT_WIDTH, cycle limit for WAIT and HOLD; 0 disables timeout.
- busy_o, out, 1, state != IDLE.
- timeout_err_o, out, 1, one-cycle pulse on timeout.

Function
REQ-003 The FSM SHALL have exactly four states: IDLE, SEND, WAIT, HOLD.

REQ-004 IDLE, any req_valid_i set:
- Select the winner round-robin, searching upward from index ptr+1 modulo NUM_REQ.
- Assert req_ready_o[winner] combinationally in that same cycle.
- Register req_data_i slice to tx_data_o and req_last_i bit to last_q.
- Set grant_o to the winner one-hot; go to SEND.

REQ-005 At most one req_ready_o bit SHALL be high in any cycle, and only in IDLE or HOLD.

REQ-006 SEND SHALL last exactly one cycle with tx_enable_o=1; then go to WAIT with the timeout counter cleared.

REQ-007 tx_data_o and grant_o SHALL hold stable from SEND until the next byte acceptance or until return to IDLE.

REQ-008 WAIT, on tx_complete_i:
- If last_q=1: go to IDLE, set ptr to the granted index, clear grant_o.
- If last_q=0: go to HOLD with the counter cleared.

REQ-009 HOLD SHALL serve only the granted requester:
- Its req_valid_i asserts req_ready_o for that index, registers data/last, and goes to SEND.
- Other requesters receive no ready.

REQ-010 Timeout counter behaviour:
- Increments by 1 each cycle in WAIT and HOLD; saturates at all-ones.
- Timeout occurs when counter == timeout_val_i and timeout_val_i != 0.
- On timeout: timeout_err_o=1 for one cycle, burst lock dropped, ptr set to the granted index, grant_o cleared, go to IDLE.

REQ-011 When tx_complete_i and a timeout occur in the same WAIT cycle, completion SHALL take priority and no timeout_err_o SHALL be raised.

REQ-012 tx_complete_i SHALL be ignored in IDLE, SEND and HOLD.

REQ-013 A requester dropping req_valid_i without a handshake SHALL have no effect; data is only sampled on valid && ready.

REQ-014 A requester with a single valid request SHALL be granted within NUM_REQ bursts of any other activity (no starvation).

Reset
REQ-015 While axi_a_rst_n_i=0, the block SHALL set, asynchronously:
- State IDLE; ptr = NUM_REQ-1, so requester 0 has first priority.
- last_q=0; counter=0.
- All outputs 0: req_ready_o, grant_o, tx_enable_o, tx_data_o, busy_o, timeout_err_o.

REQ-016 Reset asserted mid-transfer SHALL abort the transfer with no further tx_enable_o pulse and no timeout_err_o.

REQ-017 After reset release, the first active clock edge SHALL behave as IDLE.

Verification
REQ-018 Single byte: req_valid_i=4'b0001, data 0x55, last=1:
- Same cycle: req_ready_o=0001.
- Next cycle: tx_enable_o pulse with tx_data_o=0x55, grant_o=0001.
- tx_complete_i: IDLE, busy_o=0.

REQ-019 Fairness: all four valid with last=1, continuously:
- Grants in order 0,1,2,3,0.
- Exactly one tx_enable_o per tx_complete_i.

REQ-020 Burst lock:
- Requester 2 sends 0xA1 (last=0) then 0xA2 (last=1) while requester 0 is valid throughout.
- Requester 0 receives no ready until after 0xA2 completes; then requester 0 is granted (search from 3 wraps to 0).

REQ-021 Timeout: timeout_val_i=10, tx_complete_i never sent:
- timeout_err_o pulses 10 cycles after entering WAIT, then IDLE.
- With timeout_val_i=0: WAIT is held indefinitely.

REQ-022 Collision: tx_complete_i in the same cycle the counter reaches timeout_val_i -> normal completion, timeout_err_o stays 0.

REQ-023 Reset during WAIT -> all outputs 0 immediately; the next request is granted starting at requester 0.
